// File: rtl/vco_readout_pkg.sv
// vco_readout_pkg: shared FSM states, warmup length and phase-state count for the VCO readout.
package vco_readout_pkg;
  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
  localparam int WARMUP_CYCLES = 4;
  function automatic int n_states(input int pw);
    return 2 * pw;
  endfunction
endpackage

// File: rtl/vco_phase_to_bin.sv
// vco_phase_to_bin: rotation-thermometer phase word to phase index; bubble flag with VCO_BUBBLE_FLAG_EN.
module vco_phase_to_bin
  import vco_readout_pkg::*;
#(
  parameter int PHASE_WIDTH = 11,
  parameter int SW = $clog2(n_states(PHASE_WIDTH))
) (
  input  logic [PHASE_WIDTH-1:0] p,
  output logic [SW-1:0]          s
`ifdef VCO_BUBBLE_FLAG_EN
  ,
  output logic                   bubble
`endif
);
  logic [SW-1:0] pc;
  always_comb begin
    pc = '0;
    for (int i = 0; i < PHASE_WIDTH; i++) pc = pc + SW'(p[i]);
    s = (p[0] || p == '0) ? pc : SW'(n_states(PHASE_WIDTH)) - pc;
  end
`ifdef VCO_BUBBLE_FLAG_EN
  logic [PHASE_WIDTH-1:0] ones;
  assign ones = '1;
  // re-encode the decoded index; any difference means the word was not a valid rotation
  assign bubble = p != ((s <= SW'(PHASE_WIDTH)) ? ones >> (SW'(PHASE_WIDTH) - s)
                                                : ones << (s - SW'(PHASE_WIDTH)));
`endif
endmodule

// File: rtl/vco_phase_readout.sv
// vco_phase_readout: VCO phase sampler, decimating accumulator and valid/ready sample output.
// Optional VCO_BUBBLE_FLAG_EN adds the saturating bubble_cnt port.
module vco_phase_readout
  import vco_readout_pkg::*;
#(
  parameter int PHASE_WIDTH = 11,
  parameter int DECIM = 512,
  parameter int SMP_W = $clog2((2 * PHASE_WIDTH - 1) * DECIM + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   vco_enb,
  input  logic [PHASE_WIDTH-1:0] vco_p,
  output logic [SMP_W-1:0]       smp_data,
  output logic                   smp_valid,
  input  logic                   smp_ready,
  output logic                   ovf,
  input  logic                   ovf_clr
`ifdef VCO_BUBBLE_FLAG_EN
  ,
  output logic [15:0]            bubble_cnt
`endif
);
  localparam int NS = n_states(PHASE_WIDTH);
  localparam int SW = $clog2(NS);
  localparam int CW = $clog2(DECIM);
  localparam int WW = $clog2(WARMUP_CYCLES);
  logic [PHASE_WIDTH-1:0] p1, p2;
  logic [SW-1:0] s_dec, s_q, s_prev, d;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic [SMP_W-1:0] acc, frame_sum;
  logic frame_done;
  state_t state;
`ifdef VCO_BUBBLE_FLAG_EN
  logic bub_dec, bub_q;
`endif
  vco_phase_to_bin #(.PHASE_WIDTH(PHASE_WIDTH), .SW(SW)) u_dec (
    .p(p2),
    .s(s_dec)
`ifdef VCO_BUBBLE_FLAG_EN
    ,
    .bubble(bub_dec)
`endif
  );
  // modular step; the wrap-around form is exact because the true step always fits SW bits
  assign d = (s_q >= s_prev) ? s_q - s_prev : s_q + SW'(NS) - s_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
      s_q <= '0;
      s_prev <= '0;
    end else begin
      p1 <= vco_p;
      p2 <= p1;
      s_q <= s_dec;
      s_prev <= s_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vco_enb <= 1'b1;
      wcnt <= '0;
      cnt <= '0;
      acc <= '0;
      frame_sum <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          acc <= '0;
          cnt <= '0;
          wcnt <= '0;
          if (en) begin
            state <= WARMUP;
            vco_enb <= 1'b0;
          end
        end
        WARMUP: begin
          if (!en) begin
            state <= IDLE;
            vco_enb <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == WW'(WARMUP_CYCLES - 1)) state <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            vco_enb <= 1'b1;
          end else if (cnt == CW'(DECIM - 1)) begin
            frame_sum <= acc + SMP_W'(d);
            frame_done <= 1'b1;
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= acc + SMP_W'(d);
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_data <= '0;
      smp_valid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (frame_done && !(smp_valid && !smp_ready)) begin
        smp_data <= frame_sum;
        smp_valid <= 1'b1;
      end else if (smp_valid && smp_ready) begin
        smp_valid <= 1'b0;
      end
      ovf <= (frame_done & smp_valid & ~smp_ready) | (ovf & ~ovf_clr);
    end
  end
`ifdef VCO_BUBBLE_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bub_q <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      bub_q <= bub_dec;
      if (bub_q && state != IDLE && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vco_phase_readout.sv
// tb_vco_phase_readout: table-driven and randomized checks of vco_phase_readout against a frame-sum model.
module tb_vco_phase_readout;
  localparam int N = 11;
  localparam int D = 512;
  localparam int NS = 2 * N;
  logic clk = 1'b0;
  logic rst, en, vco_enb, smp_valid, smp_ready, ovf, ovf_clr;
  logic [N-1:0] vco_p;
  logic [13:0] smp_data;
`ifdef VCO_BUBBLE_FLAG_EN
  logic [15:0] bubble_cnt;
`endif
  always #5 clk = ~clk;

  vco_phase_readout dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .vco_enb(vco_enb),
    .vco_p(vco_p),
    .smp_data(smp_data),
    .smp_valid(smp_valid),
    .smp_ready(smp_ready),
    .ovf(ovf),
    .ovf_clr(ovf_clr)
`ifdef VCO_BUBBLE_FLAG_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {int step; int exp;} vec_t;
  vec_t vecs[5];
  int vectors = 0;
  int miscompares = 0;
  int j = 0;
  int phase = 0;
  int step = 0;
  int fsum = 0;
  int fcnt = 0;
  bit rnd_step = 0;
  bit rnd_ready = 0;
  bit bub = 0;
  int exp_q[$];
  int got_q[$];
  int vt_q[$];

  function automatic logic [N-1:0] code(input int s);
    int c;
    c = (s <= N) ? (1 << s) - 1 : ((1 << N) - 1) & ~((1 << (s - N)) - 1);
    return N'(c);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (j=%0d)", name, act, exp, j);
    end
  endtask

  // one clock: VCO advances, model sums the increments in D-cycle frames, transfers are logged
  task automatic tick();
    int inc;
    @(posedge clk);
    @(negedge clk);
    j++;
    inc = rnd_step ? int'($urandom_range(0, NS - 1)) : step;
    phase = (phase + inc) % NS;
    if (j >= 1 && en) begin
      fsum += inc;
      fcnt++;
      if (fcnt == D) begin
        exp_q.push_back(fsum);
        fsum = 0;
        fcnt = 0;
      end
    end
    vco_p = bub ? 11'b00000000101 : code(phase);
    if (rnd_ready) smp_ready = 1'($urandom_range(0, 1));
    if (smp_valid && smp_ready) begin
      got_q.push_back(int'(smp_data));
      vt_q.push_back(j);
    end
  endtask

  task automatic run_to(input int t);
    while (j < t) tick();
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    vt_q.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    en = 1'b0;
    smp_ready = 1'b1;
    ovf_clr = 1'b0;
    rnd_step = 0;
    rnd_ready = 0;
    bub = 0;
    step = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    clear_q();
  endtask

  task automatic start();
    en = 1'b1;
    j = -1;
    fsum = 0;
    fcnt = 0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    smp_ready = 1'b1;
    ovf_clr = 1'b0;
    vco_p = code(0);
    vecs[0] = '{1, 512};
    vecs[1] = '{3, 1536};
    vecs[2] = '{0, 0};
    vecs[3] = '{21, 10752};
    vecs[4] = '{5, 2560};
    reset_dut();
    chk("rst_vco_enb", vco_enb, 1);
    chk("rst_valid", smp_valid, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_ovf", ovf, 0);
`ifdef VCO_BUBBLE_FLAG_EN
    chk("rst_bubble_cnt", bubble_cnt, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      reset_dut();
      step = vecs[i].step;
      start();
      chk("vco_enb_fall", vco_enb, 0);
      run_to(2 * D + 6);
      chk("n_samples", got_q.size(), 2);
      for (int k = 0; k < got_q.size() && k < 2; k++) begin
        chk("sample", got_q[k], vecs[i].exp);
        chk("valid_time", vt_q[k], 5 + D * (k + 1));
      end
      chk("ovf_clean", ovf, 0);
    end
    reset_dut();
    rnd_step = 1;
    rnd_ready = 1;
    start();
    run_to(6 * D + 40);
    rnd_ready = 0;
    smp_ready = 1'b1;
    repeat (4) tick();
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) chk("rnd_sample", got_q[k], exp_q[k]);
    chk("rnd_ovf", ovf, 0);
    reset_dut();
    step = 1;
    smp_ready = 1'b0;
    start();
    run_to(D + 5);
    chk("hold_valid", smp_valid, 1);
    chk("hold_data", smp_data, 512);
    chk("hold_ovf", ovf, 0);
    run_to(2 * D + 5);
    chk("drop_ovf", ovf, 1);
    chk("drop_valid", smp_valid, 1);
    chk("drop_data", smp_data, 512);
    run_to(3 * D + 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("drop_wins_clr", ovf, 1);
    chk("drop_keep_data", smp_data, 512);
    smp_ready = 1'b1;
    tick();
    chk("deliver_clears_valid", smp_valid, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    reset_dut();
    step = 1;
    start();
    run_to(D + 5 + 300);
    en = 1'b0;
    tick();
    chk("en_off_vco_enb", vco_enb, 1);
    run_to(1400);
    chk("no_partial_sample", got_q.size(), 1);
    chk("no_partial_valid", smp_valid, 0);
    clear_q();
    start();
    run_to(D + 8);
    chk("reen_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("reen_sample", got_q[0], 512);
      chk("reen_time", vt_q[0], D + 5);
    end
`ifdef VCO_BUBBLE_FLAG_EN
    reset_dut();
    step = 1;
    start();
    run_to(99);
    bub = 1;
    repeat (3) tick();
    bub = 0;
    run_to(110);
    chk("bubble_cnt", bubble_cnt, 3);
`endif
    reset_dut();
    step = 1;
    smp_ready = 1'b0;
    start();
    run_to(2 * D + 80);
    chk("pre_rst_ovf", ovf, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_vco_enb", vco_enb, 1);
    chk("mid_rst_valid", smp_valid, 0);
    chk("mid_rst_data", smp_data, 0);
    chk("mid_rst_ovf", ovf, 0);
`ifdef VCO_BUBBLE_FLAG_EN
    chk("mid_rst_bubble", bubble_cnt, 0);
`endif
    rst = 1'b0;
    smp_ready = 1'b1;
    clear_q();
    start();
    chk("post_rst_warmup", vco_enb, 0);
    run_to(D + 8);
    chk("post_rst_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("post_rst_sample", got_q[0], 512);
      chk("post_rst_time", vt_q[0], D + 5);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
